// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb - round-robin read arbiter popping bursts from NUM_CH FIFO read ports into one registered valid/ready output.
// Optional: FIFO_RD_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin in IDLE.
module fifo_rd_arb #(
   parameter int NUM_CH    = 4,
   parameter int D_SIZE    = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                       r_clk,
   input  logic                       r_rst,
   input  logic [NUM_CH-1:0]          ch_empty,
   input  logic [NUM_CH*D_SIZE-1:0]   ch_rd_data,
   output logic [NUM_CH-1:0]          ch_r_inc,
   output logic [D_SIZE-1:0]          out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(NUM_CH)-1:0]  grant_id,
   output logic                       busy
);

   localparam int GW = $clog2(NUM_CH);
   localparam int BW = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     grant_id_q, grant_id_d;
   logic [GW-1:0]     last_grant_q, last_grant_d;
   logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
   logic              hold_q, hold_d;
   logic [D_SIZE-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;

   logic [GW-1:0]     pick_idx;
   logic              any_ready;
   logic              cur_empty;
   logic [D_SIZE-1:0] cur_data;
   logic              pop;
   int                search_idx;

   assign any_ready = ~&ch_empty;

   always_comb begin
      pick_idx   = '0;
      search_idx = 0;
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (!ch_empty[i]) pick_idx = GW'(i);
      end
`else
      // Walk the search order backwards so the earliest candidate after last_grant overwrites the rest.
      for (int k = NUM_CH; k >= 1; k--) begin
         search_idx = int'(last_grant_q) + k;
         if (search_idx >= NUM_CH) search_idx = search_idx - NUM_CH;
         if (!ch_empty[GW'(search_idx)]) pick_idx = GW'(search_idx);
      end
`endif
   end

   assign cur_empty = ch_empty[grant_id_q];
   assign cur_data  = ch_rd_data[grant_id_q*D_SIZE +: D_SIZE];
   assign pop = (state_q == BURST) && !cur_empty && (!out_valid_q || out_ready)
                && !hold_q && (beat_cnt_q < BW'(BURST_LEN));

   always_comb begin
      ch_r_inc           = '0;
      ch_r_inc[grant_id_q] = pop;
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      hold_d       = pop;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;

      if (pop) begin
         out_data_d  = cur_data;
         out_valid_d = 1'b1;
         beat_cnt_d  = beat_cnt_q + 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (any_ready) begin
               grant_id_d = pick_idx;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            // The empty flag lags a pop by one cycle, so it is only trusted outside the hold cycle.
            if ((beat_cnt_q == BW'(BURST_LEN)) || (cur_empty && !hold_q)) begin
               last_grant_d = grant_id_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= GW'(NUM_CH - 1);
         beat_cnt_q   <= '0;
         hold_q       <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         hold_q       <= hold_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign grant_id  = grant_id_q;
   assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb/tb_fifo_rd_arb.sv - randomized and directed checks of fifo_rd_arb against a behavioural FIFO/arbiter model.
module tb_fifo_rd_arb;

   localparam int NUM_CH = 4;
   localparam int D_SIZE = 8;
   localparam int BL     = 4;

   logic                     r_clk = 1'b0;
   logic                     r_rst;
   logic [NUM_CH-1:0]        ch_empty;
   logic [NUM_CH*D_SIZE-1:0] ch_rd_data;
   logic [NUM_CH-1:0]        ch_r_inc;
   logic [D_SIZE-1:0]        out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [1:0]               grant_id;
   logic                     busy;

   fifo_rd_arb #(.NUM_CH(NUM_CH), .D_SIZE(D_SIZE), .BURST_LEN(BL)) dut (
      .r_clk(r_clk), .r_rst(r_rst), .ch_empty(ch_empty), .ch_rd_data(ch_rd_data),
      .ch_r_inc(ch_r_inc), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .grant_id(grant_id), .busy(busy)
   );

   always #5 r_clk = ~r_clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] fq[NUM_CH][$];
   int         m_busy, m_g, m_beats, m_last, m_last_pop, m_ov;
   logic [7:0] m_od;
   int         cyc = 0;
   logic       prev_busy = 1'b0;
   int         glog[$];
   logic [7:0] acc[$];
   int         inc_cnt = 0;
   bit         rnd_push = 0, rnd_ready = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_CH; i++) begin
         ch_empty[i] = (fq[i].size() == 0);
         ch_rd_data[i*D_SIZE +: D_SIZE] = (fq[i].size() != 0) ? fq[i][0] : 8'($urandom);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_g = 0; m_beats = 0; m_last = NUM_CH - 1;
      m_last_pop = -10; m_ov = 0; m_od = 8'h00; prev_busy = 1'b0;
   endtask

   function automatic int pick();
      int r = 0;
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
      for (int i = NUM_CH - 1; i >= 0; i--) if (fq[i].size() != 0) r = i;
`else
      for (int k = NUM_CH; k >= 1; k--) if (fq[(m_last + k) % NUM_CH].size() != 0) r = (m_last + k) % NUM_CH;
`endif
      return r;
   endfunction

   // One clock: compare at negedge, advance the model, then drive new inputs just after posedge.
   task automatic step();
      bit         exp_pop, accept, any, g_empty;
      logic [3:0] exp_inc;
      @(negedge r_clk);
      g_empty = (fq[m_g].size() == 0);
      exp_pop = (m_busy != 0) && !g_empty && (m_ov == 0 || out_ready) &&
                (cyc - m_last_pop >= 2) && (m_beats < BL);
      exp_inc = exp_pop ? 4'(1 << m_g) : 4'b0;
      chk("ch_r_inc", 32'(ch_r_inc), 32'(exp_inc));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_g));
      if (busy && !prev_busy) glog.push_back(int'(grant_id));
      prev_busy = busy;
      if (ch_r_inc != 0) inc_cnt++;
      if (out_valid && out_ready) acc.push_back(out_data);

      accept = (m_ov != 0) && out_ready;
      any = 0;
      for (int i = 0; i < NUM_CH; i++) if (fq[i].size() != 0) any = 1;
      if (m_busy != 0) begin
         if (exp_pop) begin
            m_od = fq[m_g].pop_front();
            m_ov = 1; m_beats++; m_last_pop = cyc;
         end else begin
            if (accept) m_ov = 0;
            if (m_beats == BL || (g_empty && cyc - m_last_pop >= 2)) begin
               m_busy = 0; m_last = m_g;
            end
         end
      end else begin
         if (accept) m_ov = 0;
         if (any) begin
            m_g = pick(); m_beats = 0; m_busy = 1;
         end
      end
      cyc++;
      @(posedge r_clk);
      #1;
      if (rnd_push)
         for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(3) == 0 && fq[i].size() < 8) fq[i].push_back(8'($urandom));
      if (rnd_ready) out_ready = ($urandom_range(2) != 0);
      drive();
   endtask

   task automatic drain(input string name);
      int n = 0;
      bit done = 0;
      while (!done && n < 400) begin
         done = !busy && !out_valid;
         for (int i = 0; i < NUM_CH; i++) if (fq[i].size() != 0) done = 0;
         if (!done) begin step(); n++; end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL %s drain_timeout actual=%0d required<400", name, n);
      end
   endtask

   task automatic sync_reset();
      r_rst = 1'b1;
      @(posedge r_clk); @(posedge r_clk); #1;
      r_rst = 1'b0;
      model_reset();
      drive();
   endtask

   // Pulse reset between edges and expect every output to clear without a clock.
   task automatic async_reset();
      #2 r_rst = 1'b1;
      #1;
      chk("arst_inc", 32'(ch_r_inc), 0);
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_data", 32'(out_data), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_grant", 32'(grant_id), 0);
      @(posedge r_clk); @(posedge r_clk); #1;
      r_rst = 1'b0;
      model_reset();
      drive();
   endtask

   initial begin
      r_rst = 1'b1;
      out_ready = 1'b1;
      model_reset();
      drive();
      sync_reset();

      // All channels empty: nothing happens.
      for (int i = 0; i < 20; i++) step();
      chk("t1_no_grants", glog.size(), 0);
      chk("t1_no_pops", inc_cnt, 0);

      // Channel 2 with six words: bursts of 4 then 2.
      sync_reset();
      glog.delete(); acc.delete();
      for (int i = 0; i < 6; i++) fq[2].push_back(8'hA0 + 8'(i));
      drive();
      drain("t2");
      chk("t2_acc_n", acc.size(), 6);
      for (int i = 0; i < 6 && i < acc.size(); i++) chk("t2_word", 32'(acc[i]), 32'hA0 + i);
      chk("t2_grants", glog.size(), 2);
      if (glog.size() == 2) begin
         chk("t2_g0", glog[0], 2);
         chk("t2_g1", glog[1], 2);
      end

      // Channels 0, 1, 3 with six words each.
      sync_reset();
      glog.delete(); acc.delete();
      for (int i = 0; i < 6; i++) begin
         fq[0].push_back(8'h00 + 8'(i));
         fq[1].push_back(8'h10 + 8'(i));
         fq[3].push_back(8'h30 + 8'(i));
      end
      drive();
      drain("t3");
      chk("t3_acc_n", acc.size(), 18);
      chk("t3_grants", glog.size(), 6);
      if (glog.size() == 6) begin
`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
         chk("t3_g0", glog[0], 0); chk("t3_g1", glog[1], 0); chk("t3_g2", glog[2], 1);
         chk("t3_g3", glog[3], 1); chk("t3_g4", glog[4], 3); chk("t3_g5", glog[5], 3);
`else
         chk("t3_g0", glog[0], 0); chk("t3_g1", glog[1], 1); chk("t3_g2", glog[2], 3);
         chk("t3_g3", glog[3], 0); chk("t3_g4", glog[4], 1); chk("t3_g5", glog[5], 3);
`endif
      end

      // Backpressure on channel 1.
      sync_reset();
      acc.delete(); inc_cnt = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) fq[1].push_back(8'hB0 + 8'(i));
      drive();
      for (int i = 0; i < 12; i++) step();
      chk("t4_stall_pops", inc_cnt, 1);
      chk("t4_held_data", 32'(out_data), 32'hB0);
      chk("t4_held_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      drain("t4");
      chk("t4_total_pops", inc_cnt, 4);
      chk("t4_acc_n", acc.size(), 4);
      for (int i = 0; i < 4 && i < acc.size(); i++) chk("t4_word", 32'(acc[i]), 32'hB0 + i);

      // Channel 0 runs dry after two beats.
      sync_reset();
      glog.delete(); inc_cnt = 0;
      fq[0].push_back(8'h51); fq[0].push_back(8'h52);
      drive();
      drain("t5");
      chk("t5_pops", inc_cnt, 2);
      chk("t5_grants", glog.size(), 1);

      // Reset mid-burst on channel 1, then channel 0 must win.
      sync_reset();
      inc_cnt = 0;
      for (int i = 0; i < 4; i++) fq[1].push_back(8'hC0 + 8'(i));
      drive();
      for (int n = 0; n < 40 && inc_cnt < 2; n++) step();
      chk("t6_valid_before", 32'(out_valid), 1);
      async_reset();
      glog.delete();
      fq[0].push_back(8'hD0); fq[0].push_back(8'hD1);
      drive();
      drain("t6");
      chk("t6_grants", glog.size(), 2);
      if (glog.size() == 2) begin
         chk("t6_g0", glog[0], 0);
         chk("t6_g1", glog[1], 1);
      end

      // Randomized traffic with random backpressure and one asynchronous reset.
      sync_reset();
      rnd_push = 1; rnd_ready = 1;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (i == 1500) async_reset();
      end
      rnd_push = 0; rnd_ready = 0; out_ready = 1'b1;
      drain("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
